// File: rtl/fifo_prog_flags.sv
// Synchronous circular-queue FIFO with occupancy count, programmable almost flags and sticky errors.
// Registered 1-cycle read by default; define FIFO_FWFT_EN for first-word fall-through (zero read latency).
module fifo_prog_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_AF   = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_AE   = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // A read from a full FIFO frees the slot the simultaneous write lands in.
  assign w_rd_ok = rd && !r_empty;
  assign w_wr_ok = wr && (!r_full || w_rd_ok);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && !reset) begin
      r_mem[r_wptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= CNT_AF);
      r_ae    <= (w_count_nxt <= CNT_AE);
    end
  end

  // Setting an error takes priority over clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr && !w_wr_ok)  r_ovf <= 1'b1;
      else if (clr_err)    r_ovf <= 1'b0;
      if (rd && !w_rd_ok)  r_udf <= 1'b1;
      else if (clr_err)    r_udf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign r_data  = r_mem[r_rptr];
  assign r_valid = !r_empty;
`else
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      if (w_rd_ok) r_rdata <= r_mem[r_rptr];
    end
  end

  assign r_data  = r_rdata;
  assign r_valid = r_rvalid;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_prog_flags.sv
// Directed-vector bench for fifo_prog_flags (8x8, AF=6, AE=2); adapts read checks when FIFO_FWFT_EN is defined.
module tb_fifo_prog_flags;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_vec;
  int n_err;

  fifo_prog_flags #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .r_valid      (r_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic do_op(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr      = w;
    w_data  = d;
    rd      = r;
    clr_err = c;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic push_chk(input logic [7:0] d, input int exp_cnt);
    do_op(1'b1, d, 1'b0, 1'b0);
    chk("push_count", count, exp_cnt);
    chk("push_full",  full,  exp_cnt == 8);
    chk("push_empty", empty, exp_cnt == 0);
    chk("push_af",    almost_full,  exp_cnt >= 6);
    chk("push_ae",    almost_empty, exp_cnt <= 2);
  endtask

  task automatic pop_chk(input logic [7:0] exp, input int exp_cnt);
`ifdef FIFO_FWFT_EN
    chk("fwft_head",  r_data,  exp);
    chk("fwft_valid", r_valid, 1'b1);
    do_op(1'b0, 8'h00, 1'b1, 1'b0);
`else
    do_op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_data",  r_data,  exp);
    chk("pop_valid", r_valid, 1'b1);
`endif
    chk("pop_count", count, exp_cnt);
    chk("pop_empty", empty, exp_cnt == 0);
  endtask

  logic [7:0] fill_v [8];
  logic [7:0] drain_v [8];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    wr      = 1'b0;
    rd      = 1'b0;
    w_data  = 8'h00;
    clr_err = 1'b0;
    fill_v  = '{8'd5, 8'd8, 8'd12, 8'd2, 8'd9, 8'd14, 8'd13, 8'd6};
    drain_v = '{8'd8, 8'd12, 8'd2, 8'd9, 8'd14, 8'd13, 8'd6, 8'h55};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full",  full,  1'b0);
    chk("rst_af",    almost_full,  1'b0);
    chk("rst_ae",    almost_empty, 1'b1);
    chk("rst_ovf",   overflow,  1'b0);
    chk("rst_udf",   underflow, 1'b0);
    chk("rst_valid", r_valid,   1'b0);
`ifndef FIFO_FWFT_EN
    chk("rst_rdata", r_data, 8'h00);
`endif

    // Fill to full
    for (int i = 0; i < 8; i++) push_chk(fill_v[i], i + 1);

    // Overflow: dropped write, then clear
    do_op(1'b1, 8'd7, 1'b0, 1'b0);
    chk("ovf_count", count, 8);
    chk("ovf_flag",  overflow, 1'b1);
    chk("ovf_udf",   underflow, 1'b0);
    do_op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 1'b0);

    // Drain; the rejected 7 must not appear
    for (int i = 0; i < 8; i++) pop_chk(fill_v[i], 7 - i);
    do_op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_flag",  underflow, 1'b1);
    chk("udf_valid", r_valid,   1'b0);
    chk("udf_count", count, 0);
    // Set wins over a concurrent clear
    do_op(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_set_wins", underflow, 1'b1);
    do_op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", underflow, 1'b0);

    // Wrap-around
    for (int i = 0; i < 3; i++) push_chk(8'(i + 1), i + 1);
    for (int i = 0; i < 3; i++) pop_chk(8'(i + 1), 2 - i);
    for (int i = 0; i < 8; i++) push_chk(8'hA0 + 8'(i), i + 1);
    for (int i = 0; i < 8; i++) pop_chk(8'hA0 + 8'(i), 7 - i);

    // Simultaneous read/write while full
    for (int i = 0; i < 8; i++) push_chk(fill_v[i], i + 1);
`ifdef FIFO_FWFT_EN
    chk("sim_full_head", r_data, 8'd5);
    do_op(1'b1, 8'h55, 1'b1, 1'b0);
`else
    do_op(1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_full_data",  r_data,  8'd5);
    chk("sim_full_valid", r_valid, 1'b1);
`endif
    chk("sim_full_count", count, 8);
    chk("sim_full_ovf",   overflow, 1'b0);
    chk("sim_full_flag",  full, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk(drain_v[i], 7 - i);

    // Simultaneous read/write while empty
    do_op(1'b1, 8'h11, 1'b1, 1'b0);
    chk("sim_empty_count", count, 1);
    chk("sim_empty_udf",   underflow, 1'b1);
    chk("sim_empty_ovf",   overflow,  1'b0);
`ifndef FIFO_FWFT_EN
    chk("sim_empty_valid", r_valid, 1'b0);
`endif
    pop_chk(8'h11, 0);

    // Reset mid-operation, with requests and a set error flag present
    for (int i = 0; i < 4; i++) push_chk(8'hC0 + 8'(i), i + 1);
    reset = 1'b1;
    do_op(1'b1, 8'hEE, 1'b1, 1'b0);
    reset = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1'b1);
    chk("mrst_ae",    almost_empty, 1'b1);
    chk("mrst_full",  full, 1'b0);
    chk("mrst_valid", r_valid, 1'b0);
    chk("mrst_ovf",   overflow,  1'b0);
    chk("mrst_udf",   underflow, 1'b0);
    push_chk(8'h33, 1);
    pop_chk(8'h33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
